log2_seq: RTL

- Parametrised sequential unsigned base-2 logarithm unit for the calculator datapath.
- Computes log2(N) for any N of width IN_W.
- Integer part comes from a leading-one detector; fractional bits come from iterated mantissa squaring, one bit per cycle.
- Adds a start/busy/done handshake, zero-input error, synchronous clear and configurable precision.

---
 rtl/log2_pkg.sv | 24 ++
 rtl/log2_norm.sv | 25 ++
 rtl/log2_seq.sv | 110 +++++++++++
 3 files changed

// File: rtl/log2_pkg.sv
// Shared types, defaults and helpers for the sequential base-2 logarithm unit.
package log2_pkg;

   localparam int unsigned IN_W_DEF   = 16;
   localparam int unsigned FRAC_W_DEF = 24;
   localparam int unsigned MW_DEF     = 32;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      DONE
   } state_t;

   // Index of the most significant set bit; 0 for a zero operand.
   function automatic int unsigned lead_one(input logic [63:0] v);
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < 64; i++) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/log2_norm.sv
// Leading-one detector and normaliser: yields the integer log and a Q1.(MW-1)
// mantissa in [1,2) for a nonzero operand.
module log2_norm
   import log2_pkg::*;
#(
   parameter  int unsigned IN_W  = IN_W_DEF,
   parameter  int unsigned MW    = MW_DEF,
   localparam int unsigned INT_W = $clog2(IN_W)
) (
   input  logic [IN_W-1:0]  in_value,
   output logic [INT_W-1:0] k,
   output logic [MW-1:0]    m,
   output logic             is_zero
);

   int unsigned idx;

   always_comb begin
      idx     = lead_one(64'(in_value));
      is_zero = (in_value == '0);
      k       = INT_W'(idx);
      m       = (MW'(in_value) << (MW - IN_W)) << (IN_W - 1 - idx);
   end

endmodule

// File: rtl/log2_seq.sv
// Sequential unsigned log2: integer part from the normaliser, one fractional
// bit per cycle from repeated mantissa squaring.
module log2_seq
   import log2_pkg::*;
#(
   parameter  int unsigned IN_W   = IN_W_DEF,
   parameter  int unsigned FRAC_W = FRAC_W_DEF,
   parameter  int unsigned MW     = MW_DEF,
   localparam int unsigned INT_W  = $clog2(IN_W)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    start,
   input  logic [IN_W-1:0]         in_value,
   output logic                    busy,
   output logic                    done,
   output logic                    err_zero,
   output logic [INT_W+FRAC_W-1:0] result
);

   localparam int unsigned CNT_W = $clog2(FRAC_W + 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [MW-1:0]       m_q, m_next, m_norm;
   logic [2*MW-1:0]     sq;
   logic                new_bit;
   logic [INT_W-1:0]    int_q, k;
   logic [FRAC_W-1:0]   frac_q;
   logic                is_zero;
   logic                last_iter;

   log2_norm #(.IN_W(IN_W), .MW(MW)) u_norm (
      .in_value (in_value),
      .k        (k),
      .m        (m_norm),
      .is_zero  (is_zero)
   );

   // Squaring doubles the log; an overflow past 2.0 means the next bit is 1.
   always_comb begin
      sq      = {{MW{1'b0}}, m_q} * {{MW{1'b0}}, m_q};
      new_bit = sq[2*MW-1];
      m_next  = new_bit ? sq[2*MW-1:MW] : sq[2*MW-2:MW-1];
   end

   assign last_iter = (cnt_q == CNT_W'(FRAC_W - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = is_zero ? DONE : ITER;
            ITER:    if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         int_q    <= '0;
         frac_q   <= '0;
         err_zero <= 1'b0;
         cnt_q    <= '0;
         m_q      <= '0;
      end else if (clear) begin
         int_q    <= '0;
         frac_q   <= '0;
         err_zero <= 1'b0;
         cnt_q    <= '0;
         m_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  int_q  <= is_zero ? '0 : k;
                  frac_q <= '0;
                  cnt_q  <= '0;
                  err_zero <= is_zero;
                  if (!is_zero) m_q <= m_norm;
               end
            end
            ITER: begin
               m_q    <= m_next;
               frac_q <= (frac_q << 1) | FRAC_W'(new_bit);
               cnt_q  <= cnt_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign result = {int_q, frac_q};

endmodule
